// File: rtl/fxp_pkg.sv
// Shared fixed-point defaults, sequencer state encoding and saturation limits.
// No logic of its own, so it adds no latency.
// Backpressure does not apply; the package only declares types and constants.
package fxp_pkg;

    localparam int FXP_WIDTH        = 32;
    localparam int FXP_DECIMAL_BITS = 16;

    localparam logic [FXP_WIDTH-1:0] FXP_ONE = FXP_WIDTH'(1) << FXP_DECIMAL_BITS;
    localparam logic [FXP_WIDTH-1:0] FXP_MAX = {1'b0, {(FXP_WIDTH-1){1'b1}}};
    localparam logic [FXP_WIDTH-1:0] FXP_MIN = {1'b1, {(FXP_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/fxp_mult.sv
// Signed fixed-point multiply of two runtime operands, floor-truncated back to WIDTH bits.
// Purely combinational: zero cycles of latency.
// No handshake; the owning sequencer decides when the result is used.
module fxp_mult
    import fxp_pkg::*;
#(
    parameter int WIDTH        = FXP_WIDTH,
    parameter int DECIMAL_BITS = FXP_DECIMAL_BITS
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] term_o
);

    logic [2*WIDTH-1:0] prod;
    logic               unused_prod;

    // Explicit sign extension keeps the full-precision product exact in 2*WIDTH bits.
    assign prod = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};

    assign term_o      = prod[WIDTH-1+DECIMAL_BITS -: WIDTH];
    assign unused_prod = ^prod;

endmodule

// File: rtl/cmult_dot_seq.sv
// Dot product y = sum C[i]*x[i] through one shared multiplier; C[] runtime loadable (CMULT_DOT_SEQ_SAT_EN: saturating accumulate).
// Latency: accept at edge T, one product per cycle over T+1..T+LEN, out_valid after edge T+LEN.
// Backpressure: in_ready only in IDLE without a config write; result held in DONE until out_ready.
module cmult_dot_seq
    import fxp_pkg::*;
#(
    parameter int WIDTH        = FXP_WIDTH,
    parameter int DECIMAL_BITS = FXP_DECIMAL_BITS,
    parameter int LEN          = 6,
    localparam int CW          = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_addr,
    input  logic [WIDTH-1:0]     cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LEN*WIDTH-1:0] x_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     y_out,
    output logic                 busy
);

    localparam logic [CW:0]   LEN_W    = (CW+1)'(LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(LEN-1);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] coef_q [LEN];
    logic [WIDTH-1:0] xr_q   [LEN];
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    idx_q, idx_d;

    logic             accept;
    logic             cfg_hit;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] acc_sum;

    assign in_ready  = (state_q == ST_IDLE) && !cfg_we;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign y_out     = y_q;

    // Coefficients only move while IDLE, so a job sees one frozen set from accept to completion.
    assign cfg_hit = cfg_we && (state_q == ST_IDLE) && ({1'b0, cfg_addr} < LEN_W);

    fxp_mult #(
        .WIDTH        (WIDTH),
        .DECIMAL_BITS (DECIMAL_BITS)
    ) u_mult (
        .a_i    (coef_q[idx_q]),
        .b_i    (xr_q[idx_q]),
        .term_o (term)
    );

`ifdef CMULT_DOT_SEQ_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] sum_ext;

    assign sum_ext = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};

    // Overflow shows up as disagreement between the guard bit and the result sign bit.
    always_comb begin
        acc_sum = sum_ext[WIDTH-1:0];
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) begin
            acc_sum = sum_ext[WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign acc_sum = acc_q + term;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_MUL;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_MUL: begin
                acc_d = acc_sum;
                idx_d = idx_q + CW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    y_d     = acc_sum;
                    idx_d   = '0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LEN; i++) begin
                coef_q[i] <= '0;
            end
        end else if (cfg_hit) begin
            coef_q[cfg_addr] <= cfg_data;
        end
    end

    // Operand snapshot; needs no reset because it is always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LEN; i++) begin
                xr_q[i] <= x_vec[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_cmult_dot_seq.sv
// Scoreboard bench for cmult_dot_seq: expected results queued at accept, compared at the output handshake.
// Build with +define+CMULT_DOT_SEQ_SAT_EN to check the saturating variant.
module tb_cmult_dot_seq;

    localparam int W   = 32;
    localparam int DB  = 16;
    localparam int LEN = 6;
    localparam int CW  = 3;
    localparam logic [W-1:0] ONE = 32'h0001_0000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_we;
    logic [CW-1:0]      cfg_addr;
    logic [W-1:0]       cfg_data;
    logic               in_valid;
    logic               in_ready;
    logic [LEN*W-1:0]   x_vec;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       y_out;
    logic               busy;

    int                 n_checks = 0;
    int                 n_pass   = 0;
    logic [W-1:0]       sb [$];
    logic [W-1:0]       mc [LEN];
    logic [W-1:0]       xs [LEN];

    always #5 clk = ~clk;

    cmult_dot_seq #(.WIDTH(W), .DECIMAL_BITS(DB), .LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_vec     (x_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model_dot(input logic [W-1:0] c [LEN], input logic [W-1:0] x [LEN]);
        logic [W-1:0]        acc;
        logic signed [2*W-1:0] p;
        logic [W-1:0]        t;
        longint              s;
        acc = '0;
        for (int i = 0; i < LEN; i++) begin
            p = $signed(c[i]) * $signed(x[i]);
            t = p[W-1+DB -: W];
`ifdef CMULT_DOT_SEQ_SAT_EN
            s = longint'($signed(acc)) + longint'($signed(t));
            if (s > 64'sd2147483647)       acc = 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) acc = 32'h8000_0000;
            else                           acc = s[W-1:0];
`else
            s   = 0;
            acc = acc + t;
`endif
        end
        return acc;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
            else                chk("y_out", y_out, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input logic [W-1:0] d, input bit upd);
        cfg_we   = 1'b1;
        cfg_addr = CW'(a);
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        if (upd && a < LEN) mc[a] = d;
    endtask

    task automatic send_job(input logic [W-1:0] exp_y, output int waits);
        in_valid = 1'b1;
        for (int i = 0; i < LEN; i++) x_vec[i*W +: W] = xs[i];
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        sb.push_back(exp_y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 50);
        if (!out_valid) chk("out_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w;
        int lat;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        x_vec     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            mc[i] = '0;
            xs[i] = '0;
        end
        repeat (2) tick();
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_y_out",     y_out,              32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // All-ones coefficients, x = 1..6 -> 21.0, with latency check.
        for (int i = 0; i < LEN; i++) begin
            cfg_write(i, ONE, 1'b1);
            xs[i] = ONE * (i + 1);
        end
        send_job(32'h0015_0000, w);
        chk("idle_accept_wait", 32'(w), 32'd0);
        @(negedge clk);
        chk("mul_in_ready", {31'b0, in_ready}, 32'd0);
        chk("mul_busy",     {31'b0, busy},     32'd1);
        tick();
        wait_out(lat);
        chk("latency", 32'(lat + 1), 32'd6);
        wait_idle();

        // Negative coefficient, then the floor-truncation edge.
        for (int i = 0; i < LEN; i++) begin
            cfg_write(i, (i == 0) ? 32'hFFFF_8000 : 32'h0, 1'b1);
            xs[i] = '0;
        end
        xs[0] = 32'h0002_0000;
        send_job(32'hFFFF_0000, w);
        wait_out(lat);
        wait_idle();
        cfg_write(0, 32'h0000_0001, 1'b1);
        xs[0] = 32'hFFFF_FFFF;
        send_job(32'hFFFF_FFFF, w);
        wait_out(lat);
        wait_idle();

        // Output stall in DONE, then back-to-back accept.
        out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            cfg_write(i, W'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000, 1'b1);
            xs[i] = W'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
        end
        send_job(model_dot(mc, xs), w);
        wait_out(lat);
        for (int k = 0; k < 5; k++) begin
            chk("stall_y",         y_out,              model_dot(mc, xs));
            chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_in_ready",  {31'b0, in_ready},  32'd0);
            chk("stall_busy",      {31'b0, busy},      32'd1);
            @(negedge clk);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < LEN; i++) xs[i] = ONE * (LEN - i);
        send_job(model_dot(mc, xs), w);
        chk("b2b_wait", 32'(w), 32'd1);
        wait_out(lat);
        wait_idle();

        // Config write during MUL is dropped; out-of-range addresses are ignored.
        for (int i = 0; i < LEN; i++) begin
            cfg_write(i, ONE, 1'b1);
            xs[i] = ONE * (i + 1);
        end
        send_job(32'h0015_0000, w);
        cfg_write(2, 32'h0009_0000, 1'b0);
        wait_out(lat);
        wait_idle();
        cfg_write(6, 32'h1234_5678, 1'b1);
        cfg_write(7, 32'h8765_4321, 1'b1);

        // Config write beats a simultaneous in_valid; the accept follows next cycle.
        cfg_we   = 1'b1;
        cfg_addr = 3'd2;
        cfg_data = 32'h0009_0000;
        in_valid = 1'b1;
        for (int i = 0; i < LEN; i++) x_vec[i*W +: W] = xs[i];
        @(negedge clk);
        chk("cfgwin_in_ready", {31'b0, in_ready}, 32'd0);
        chk("cfgwin_busy",     {31'b0, busy},     32'd0);
        tick();
        cfg_we = 1'b0;
        mc[2]  = 32'h0009_0000;
        send_job(32'h002D_0000, w);
        chk("cfgwin_wait", 32'(w), 32'd0);
        wait_out(lat);
        wait_idle();

        // Reset in the middle of a job at idx 3.
        send_job(32'h002D_0000, w);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < LEN; i++) mc[i] = '0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy",      {31'b0, busy},      32'd0);
        chk("midrst_y_out",     y_out,              32'd0);
        tick();
        send_job(32'h0000_0000, w);
        wait_out(lat);
        wait_idle();

        // Overflow: 6 * 127.0^2 exceeds the Q16.16 range.
        for (int i = 0; i < LEN; i++) begin
            cfg_write(i, 32'h007F_0000, 1'b1);
            xs[i] = 32'h007F_0000;
        end
`ifdef CMULT_DOT_SEQ_SAT_EN
        send_job(32'h7FFF_FFFF, w);
`else
        send_job(32'h7A06_0000, w);
`endif
        wait_out(lat);
        wait_idle();

        // Random jobs with full-range operands.
        for (int j = 0; j < 6; j++) begin
            for (int i = 0; i < LEN; i++) begin
                cfg_write(i, W'($urandom()), 1'b1);
                xs[i] = W'($urandom());
            end
            send_job(model_dot(mc, xs), w);
            wait_out(lat);
            wait_idle();
        end

        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
